// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port controller:
// default geometry, controller state encoding and requester ids.
package regfile_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    // INIT zeroes every register after reset, ARB serves the two requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } wr_state_e;

    // Requester ids, also the encoding of the round-robin pointer.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer.
// The pointer names the requester that wins when both ask at once and
// flips to the other requester after every grant.
module rr_arbiter_2
    import regfile_pkg::*;
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic En,
    input  logic A_Req,
    input  logic B_Req,
    output logic A_Gnt,
    output logic B_Gnt
);

    logic ptr_r;

    // Grant decode: a lone request wins, contention goes to the pointer
    always_comb begin
        A_Gnt = 1'b0;
        B_Gnt = 1'b0;
        if (En) begin
            if (A_Req && (!B_Req || (ptr_r == REQ_A))) begin
                A_Gnt = 1'b1;
            end else if (B_Req) begin
                B_Gnt = 1'b1;
            end else begin
                A_Gnt = 1'b0;
                B_Gnt = 1'b0;
            end
        end else begin
            A_Gnt = 1'b0;
            B_Gnt = 1'b0;
        end
    end

    // Pointer register: hand priority to the other side after each grant
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr_r <= REQ_A;
        end else if (A_Gnt) begin
            ptr_r <= REQ_B;
        end else if (B_Gnt) begin
            ptr_r <= REQ_A;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the register file. Shares the single write port
// between requester A (writeback) and requester B (load/debug), suppresses
// writes to register 0 when R0_ZERO is set, and registers every write-port
// output so they stay stable across the whole clock period.
// Optional feature macro: RFWA_INIT_SWEEP_EN -- when defined, every reset is
// followed by a sweep that writes zero to all NUM_REGS registers.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int R0_ZERO  = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              A_Req,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_Data,
    output logic              A_Gnt,
    input  logic              B_Req,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_Data,
    output logic              B_Gnt,
    output logic              RF_WE,
    output logic [ADDR_W-1:0] RF_Awr,
    output logic [DATA_W-1:0] RF_Din,
    output logic              Init_Busy
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic              R0_FILTER = (R0_ZERO != 32'sd0);

    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              arb_en_s;
    logic              sweep_wr_s;
    logic [ADDR_W-1:0] sweep_addr_s;

    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_awr_r;
    logic [DATA_W-1:0] rf_din_r;
    logic              rf_we_nxt_s;
    logic [ADDR_W-1:0] rf_awr_nxt_s;
    logic [DATA_W-1:0] rf_din_nxt_s;

`ifdef RFWA_INIT_SWEEP_EN
    // One extra counter bit keeps the terminal count exact for any NUM_REGS.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_STEP = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);

    wr_state_e        state_r;
    wr_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // State and sweep counter registers; reset always restarts the sweep
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_INIT;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Sweep sequencing: step the address, leave INIT after the last register
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                cnt_nxt_s = cnt_r + CNT_STEP;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_ARB: begin
                state_nxt_s = ST_ARB;
                cnt_nxt_s   = cnt_r;
            end
            default: begin
                state_nxt_s = ST_INIT;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign sweep_wr_s   = (state_r == ST_INIT);
    assign sweep_addr_s = cnt_r[ADDR_W-1:0];
    assign arb_en_s     = Reset_n & (state_r == ST_ARB);
    assign Init_Busy    = (state_r == ST_INIT);
`else
    assign sweep_wr_s   = 1'b0;
    assign sweep_addr_s = ADDR_ZERO;
    assign arb_en_s     = Reset_n;
    assign Init_Busy    = 1'b0;
`endif

    // Grants are suppressed while in reset so a reset edge never loses a write.
    rr_arbiter_2 u_rr_arbiter_2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .En      (arb_en_s),
        .A_Req   (A_Req),
        .B_Req   (B_Req),
        .A_Gnt   (gnt_a_s),
        .B_Gnt   (gnt_b_s)
    );

    assign A_Gnt = gnt_a_s;
    assign B_Gnt = gnt_b_s;

    // Write-port source select: sweep, granted requester, or hold
    always_comb begin
        rf_we_nxt_s  = 1'b0;
        rf_awr_nxt_s = rf_awr_r;
        rf_din_nxt_s = rf_din_r;
        if (sweep_wr_s) begin
            rf_we_nxt_s  = 1'b1;
            rf_awr_nxt_s = sweep_addr_s;
            rf_din_nxt_s = DATA_ZERO;
        end else if (gnt_a_s) begin
            rf_we_nxt_s  = !(R0_FILTER && (A_Addr == ADDR_ZERO));
            rf_awr_nxt_s = A_Addr;
            rf_din_nxt_s = A_Data;
        end else if (gnt_b_s) begin
            rf_we_nxt_s  = !(R0_FILTER && (B_Addr == ADDR_ZERO));
            rf_awr_nxt_s = B_Addr;
            rf_din_nxt_s = B_Data;
        end else begin
            rf_we_nxt_s  = 1'b0;
            rf_awr_nxt_s = rf_awr_r;
            rf_din_nxt_s = rf_din_r;
        end
    end

    // Write-port output registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rf_we_r  <= 1'b0;
            rf_awr_r <= ADDR_ZERO;
            rf_din_r <= DATA_ZERO;
        end else begin
            rf_we_r  <= rf_we_nxt_s;
            rf_awr_r <= rf_awr_nxt_s;
            rf_din_r <= rf_din_nxt_s;
        end
    end

    assign RF_WE  = rf_we_r;
    assign RF_Awr = rf_awr_r;
    assign RF_Din = rf_din_r;

endmodule
